mux_scan_sequencer: RTL and testbench

//  Upstream driver for the 8:1 select mux. Accepts an 8-bit word over a valid/ready

---
 rtl/mux_scan_sequencer.sv | 97 +++++++++
 tb/tb_mux_scan_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// Parallel-to-serial front end for the 8:1 select mux: loads a word, walks the select, samples mux_y per position.
// Each bit appears HOLD_CYCLES clocks after its select settles; bit_ready low stalls in PRESENT with outputs frozen.
module mux_scan_sequencer #(
  parameter int HOLD_CYCLES = 1,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] mux_data,
  output logic [2:0] mux_sett,
  input  logic       mux_y,
  output logic       bit_out,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic       bit_last,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT} state_t;

  localparam logic [2:0] START_IDX = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] END_IDX   = MSB_FIRST ? 3'd0 : 3'd7;
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] hold_cnt;
  logic       accept, sample, handshake;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETTLE;
      SETTLE:  if (sample) state_nxt = PRESENT;
      PRESENT: if (handshake) state_nxt = bit_last ? IDLE : SETTLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept    = (state == IDLE) && in_valid && in_ready;
    sample    = (state == SETTLE) && (hold_cnt == HOLD_LAST);
    handshake = (state == PRESENT) && bit_valid && bit_ready;
    busy      = (state != IDLE);
  end

  // mux_data is only written on accept, so it stays put for the whole word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      mux_data  <= 8'd0;
      mux_sett  <= 3'd0;
      hold_cnt  <= 4'd0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      bit_last  <= 1'b0;
    end else begin
      if (accept) begin
        mux_data <= in_data;
        mux_sett <= START_IDX;
        hold_cnt <= 4'd0;
        in_ready <= 1'b0;
      end else if (state == IDLE) begin
        in_ready <= 1'b1;
      end

      if (state == SETTLE) begin
        hold_cnt <= hold_cnt + 4'd1;
        if (sample) begin
          bit_out   <= mux_y;
          bit_valid <= 1'b1;
          bit_last  <= (mux_sett == END_IDX);
        end
      end

      // the last position returns to IDLE instead of stepping, so the select never wraps
      if (handshake) begin
        bit_valid <= 1'b0;
        bit_last  <= 1'b0;
        if (bit_last) begin
          in_ready <= 1'b1;
        end else begin
          mux_sett <= MSB_FIRST ? (mux_sett - 3'd1) : (mux_sett + 3'd1);
          hold_cnt <= 4'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: three instances (LSB-first, MSB-first, slow hold) each closed through an 8:1 mux model.
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b0;
  logic [2:0]      in_valid = '0;
  logic [2:0][7:0] in_data  = '0;
  logic [2:0]      bit_ready = '0;
  wire  [2:0]      in_ready, bit_out, bit_valid, bit_last, busy, mux_y;
  wire  [2:0][7:0] mux_data;
  wire  [2:0][2:0] mux_sett;

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mux_scan_sequencer #(
      .HOLD_CYCLES((g == 2) ? 3 : 1),
      .MSB_FIRST  ((g == 1) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_data  (in_data[g]),
      .in_ready (in_ready[g]),
      .mux_data (mux_data[g]),
      .mux_sett (mux_sett[g]),
      .mux_y    (mux_y[g]),
      .bit_out  (bit_out[g]),
      .bit_valid(bit_valid[g]),
      .bit_ready(bit_ready[g]),
      .bit_last (bit_last[g]),
      .busy     (busy[g])
    );
    assign mux_y[g] = mux_data[g][mux_sett[g]];
  end

  function automatic int hold_of(input int k);
    return (k == 2) ? 3 : 1;
  endfunction

  function automatic bit msb_of(input int k);
    return (k == 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expects to be entered at a negedge; leaves at the negedge after the final handshake.
  // rmode: 0 ready always high, 1 random ready, 2 stall bit stall_bit for 5 cycles.
  task automatic run_word(input int k, input logic [7:0] w, input int rmode,
                          input int stall_bit, input bit pulse);
    int h, nb, cyc, stalls, scnt, pos;
    bit r, seen_first;
    h = hold_of(k); nb = 0; cyc = 0; stalls = 0; scnt = 0; seen_first = 0;
    check("idle_in_ready", in_ready[k], 1);
    in_valid[k] = 1'b1;
    in_data[k]  = w;
    @(negedge clk);
    in_valid[k] = 1'b0;
    in_data[k]  = 8'($urandom);
    while (nb < 8 && cyc < 400) begin
      pos = msb_of(k) ? 7 - nb : nb;
      check("mux_data_held", mux_data[k], w);
      check("mux_sett", mux_sett[k], pos);
      check("busy", busy[k], 1);
      check("in_ready_low", in_ready[k], 0);
      if (pulse && cyc == 2) begin
        in_valid[k] = 1'b1;
        in_data[k]  = 8'hFF;
      end else begin
        in_valid[k] = 1'b0;
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 3) != 0);
        default: r = !(nb == stall_bit && bit_valid[k] && scnt < 5);
      endcase
      if (bit_valid[k]) begin
        if (!seen_first) begin
          seen_first = 1'b1;
          check("first_latency", cyc, h);
        end
        check("bit_out", bit_out[k], w[pos]);
        check("bit_last", bit_last[k], (nb == 7));
        if (!r) begin
          stalls++;
          scnt++;
        end
      end
      bit_ready[k] = r;
      if (bit_valid[k] && r) nb++;
      @(negedge clk);
      cyc++;
    end
    in_valid[k] = 1'b0;
    if (nb < 8) begin
      check("timeout_bits", nb, 8);
    end else begin
      check("word_cycles", cyc, 8 * (h + 1) + stalls);
      check("in_ready_after", in_ready[k], 1);
      check("busy_after", busy[k], 0);
      check("bit_valid_after", bit_valid[k], 0);
    end
  endtask

  task automatic reset_and_check();
    rst_n = 1'b0;
    in_valid = '0;
    bit_ready = '0;
    #1;
    repeat (3) begin
      for (int k = 0; k < 3; k++) begin
        check("rst_in_ready", in_ready[k], 0);
        check("rst_mux_data", mux_data[k], 0);
        check("rst_mux_sett", mux_sett[k], 0);
        check("rst_bit_out", bit_out[k], 0);
        check("rst_bit_valid", bit_valid[k], 0);
        check("rst_bit_last", bit_last[k], 0);
        check("rst_busy", busy[k], 0);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", in_ready[0], 0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check("in_ready_after_release", in_ready[k], 1);
  endtask

  initial begin
    int nb, guard;
    @(negedge clk);
    reset_and_check();

    run_word(0, 8'h8d, 0, 0, 1'b0);
    run_word(0, 8'h8d, 0, 0, 1'b0);
    run_word(1, 8'h8d, 0, 0, 1'b0);
    run_word(2, 8'hA5, 2, 2, 1'b0);
    run_word(0, 8'h00, 0, 0, 1'b1);

    // abort a word after its third bit
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h8d;
    bit_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    nb = 0; guard = 0;
    while (nb < 3 && guard < 100) begin
      if (bit_valid[0]) nb++;
      @(negedge clk);
      guard++;
    end
    check("abort_reached_bit3", nb, 3);
    reset_and_check();
    run_word(0, 8'h3C, 0, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_word($urandom_range(0, 2), 8'($urandom), $urandom_range(0, 1), 0, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
